fb_fill_master: RTL
===================

// Module: fb_fill_master
// PURPOSE
//   6502-bus write initiator for the framebuffer's CPU port. Generates Phi2 from
//   the system clock and fills a rectangle of VRAM with a constant byte, using
//   standard write cycles (AddrPhys/DataOut/RW_n).
//   Optionally waits for the framebuffer's NMI (vblank), then writes the config
//   register to swap buffers. Used as a hardware clear/fill engine and as the
//   bus stimulus master in framebuffer benches.
// PARAMETERS
//   PHI2_DIV  4         Clock cycles per Phi2 half-period (Phi2 = Clock/(2*PHI2_DIV)); >=1
//   CFG_ADDR  16'h80A0  Address of framebuffer config register used for swap write
// PORTS
//   Clock     in   1   system clock
//   Reset     in   1   asynchronous, active-high reset
//   Start     in   1   command strobe; sampled only in IDLE
//   Base      in   16  address of rectangle top-left byte
//   Width     in   8   bytes per row
//   Height    in   8   number of rows
//   Stride    in   8   address increment between row starts
//   Fill      in   8   byte written to every location
//   SwapAfter in   1   after fill, wait for NMI then write SwapData to CFG_ADDR
//   SwapData  in   8   config value for swap write (e.g. 8'h05)
//   NMI_n     in   1   framebuffer NMI, active low, asynchronous to Clock
//   Busy      out  1   high from command accept until Done
//   Done      out  1   one-Clock pulse when command completes
//   Phi2      out  1   generated 6502 bus clock
//   AddrPhys  out  16  bus address
//   DataOut   out  8   bus write data
//   RW_n      out  1   0 = write cycle, 1 = read/idle
// BEHAVIOUR
// - Reset (async): Phi2=0, AddrPhys=0, DataOut=0, RW_n=1, Busy=0, Done=0, state IDLE,
//   divider=0. Reset mid-command aborts immediately; no partial cycle completes.
// - Phi2: free-running divider; toggles every PHI2_DIV Clocks. Rise strobe = the
//   Clock edge on which Phi2 goes 0->1. All bus outputs change only on rise strobes.
// - Command capture: Start in IDLE latches all command inputs and sets Busy next
//   Clock. Start while Busy is ignored. Inputs may change after capture.
// - States: IDLE, WRITE, GAP, WAIT_NMI, SWAP, SWAP_GAP, FINISH.
//   IDLE->WRITE on first rise strobe after capture (Width!=0 and Height!=0).
//   WRITE: AddrPhys=row_base+col, DataOut=Fill, RW_n=0 for exactly one Phi2 period.
//   GAP: RW_n=1 for one Phi2 period (addr/data held); then next byte in WRITE.
//   After last byte's GAP: SwapAfter ? WAIT_NMI : FINISH.
//   Width==0 or Height==0: no write cycles; go to WAIT_NMI/FINISH at first rise strobe.
//   WAIT_NMI: NMI_n double-flop synchronised; falling edge detected only while in
//   WAIT_NMI (NMI already low on entry is not an edge). On edge -> SWAP at next
//   rise strobe: AddrPhys=CFG_ADDR, DataOut=SwapData, RW_n=0 one Phi2 period;
//   SWAP_GAP: RW_n=1 one period -> FINISH.
//   FINISH: Done=1 for one Clock, Busy=0, -> IDLE. Bus outputs retain last values.
// - Arithmetic: col 8-bit counts 0..Width-1, row 0..Height-1; address =
//   row_base+col, row_base += zero-extended Stride per row; all 16-bit modulo 2^16.
// - Byte order: row-major, increasing col then row. Total writes = Width*Height.
// - Each byte costs exactly 2 Phi2 periods; swap write costs 2 more.
// TESTING
// 1 Reset asserted mid-sim -> same Clock: RW_n=1, Phi2=0, Busy=0, AddrPhys=0.
// 2 Base=8100 W=3 H=2 Stride=40 Fill=AA -> writes 8100,8101,8102,8140,8141,8142 of AA,
//   each RW_n=0 for one Phi2 period with one RW_n=1 period between; Done once after.
// 3 W=0 H=5 SwapAfter=0 -> no RW_n=0 ever; Done within 2 Phi2 periods of Start.
// 4 W=1 H=1 SwapAfter=1 SwapData=05, NMI_n held low before fill ends, then high,
//   then low -> only second falling edge triggers write 05 to 80A0; Done after it.
// 5 Base=FFFF W=2 H=2 Stride=10 -> addresses FFFF,0000,000F,0010.
// 6 Start pulsed again while Busy with different Fill -> ignored; original sequence
//   unchanged; 20-Clock Start after Done starts new command.

Source files
------------

// File: rtl/fb_fill_master.sv
// 6502-bus write master: fills a VRAM rectangle with a constant byte, optionally swaps buffers on NMI.
// Latency: first write begins on the first Phi2 rise after Start; each byte costs 2 Phi2 periods (+2 for swap).
// Backpressure: none; Start is only accepted while idle and not busy, all other Starts are dropped.
module fb_fill_master #(
    parameter int          PHI2_DIV = 4,
    parameter logic [15:0] CFG_ADDR = 16'h80A0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] Base,
    input  logic [7:0]  Width,
    input  logic [7:0]  Height,
    input  logic [7:0]  Stride,
    input  logic [7:0]  Fill,
    input  logic        SwapAfter,
    input  logic [7:0]  SwapData,
    input  logic        NMI_n,
    output logic        Busy,
    output logic        Done,
    output logic        Phi2,
    output logic [15:0] AddrPhys,
    output logic [7:0]  DataOut,
    output logic        RW_n
);

    localparam int DW = (PHI2_DIV > 1) ? $clog2(PHI2_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE, WRITE, GAP, WAIT_NMI, SWAP, SWAP_GAP, FINISH
    } state_t;

    state_t        state, nxt_state;
    logic [DW-1:0] div_cnt;
    logic          rise;

    logic [15:0]   c_base;
    logic [7:0]    c_width, c_height, c_stride, c_fill, c_swap_data;
    logic          c_swap;
    logic          load_cmd;

    logic [7:0]    col, row, nxt_col, nxt_row;
    logic [15:0]   row_base, nxt_row_base, nxt_addr;
    logic [7:0]    nxt_dout;
    logic          nxt_rw, nxt_busy, nxt_done;

    logic          nmi_s1, nmi_s2, nmi_prev, nmi_fall;
    logic          nmi_seen, nxt_seen;
    logic          last_col, last_row;

    // Free-running Phi2 divider; rise strobe marks the Clock edge where Phi2 goes high.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div_cnt <= '0;
            Phi2    <= 1'b0;
        end else if (div_cnt == DW'(PHI2_DIV - 1)) begin
            div_cnt <= '0;
            Phi2    <= ~Phi2;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign rise = (div_cnt == DW'(PHI2_DIV - 1)) && !Phi2;

    // Two-flop synchroniser for NMI_n plus a delayed copy for falling-edge detection.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            nmi_s1   <= 1'b1;
            nmi_s2   <= 1'b1;
            nmi_prev <= 1'b1;
        end else begin
            nmi_s1   <= NMI_n;
            nmi_s2   <= nmi_s1;
            nmi_prev <= nmi_s2;
        end
    end

    assign nmi_fall = nmi_prev && !nmi_s2 && (state == WAIT_NMI);

    // Command capture so the caller may change inputs once Busy is up.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            c_base      <= '0;
            c_width     <= '0;
            c_height    <= '0;
            c_stride    <= '0;
            c_fill      <= '0;
            c_swap      <= 1'b0;
            c_swap_data <= '0;
        end else if (load_cmd) begin
            c_base      <= Base;
            c_width     <= Width;
            c_height    <= Height;
            c_stride    <= Stride;
            c_fill      <= Fill;
            c_swap      <= SwapAfter;
            c_swap_data <= SwapData;
        end
    end

    // State and registered bus outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            AddrPhys <= '0;
            DataOut  <= '0;
            RW_n     <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            nmi_seen <= 1'b0;
        end else begin
            state    <= nxt_state;
            AddrPhys <= nxt_addr;
            DataOut  <= nxt_dout;
            RW_n     <= nxt_rw;
            Busy     <= nxt_busy;
            Done     <= nxt_done;
            col      <= nxt_col;
            row      <= nxt_row;
            row_base <= nxt_row_base;
            nmi_seen <= nxt_seen;
        end
    end

    assign last_col = (col == c_width - 8'd1);
    assign last_row = (row == c_height - 8'd1);

    // Next-state logic; bus-visible changes happen only on rise strobes.
    always_comb begin
        nxt_state    = state;
        nxt_addr     = AddrPhys;
        nxt_dout     = DataOut;
        nxt_rw       = RW_n;
        nxt_busy     = Busy;
        nxt_done     = 1'b0;
        nxt_col      = col;
        nxt_row      = row;
        nxt_row_base = row_base;
        nxt_seen     = nmi_seen;
        load_cmd     = 1'b0;
        case (state)
            IDLE: begin
                if (!Busy) begin
                    if (Start) begin
                        load_cmd = 1'b1;
                        nxt_busy = 1'b1;
                    end
                end else if (rise) begin
                    if (c_width != 8'd0 && c_height != 8'd0) begin
                        nxt_state    = WRITE;
                        nxt_addr     = c_base;
                        nxt_dout     = c_fill;
                        nxt_rw       = 1'b0;
                        nxt_col      = '0;
                        nxt_row      = '0;
                        nxt_row_base = c_base;
                    end else if (c_swap) begin
                        nxt_state = WAIT_NMI;
                        nxt_seen  = 1'b0;
                    end else begin
                        nxt_state = FINISH;
                        nxt_done  = 1'b1;
                        nxt_busy  = 1'b0;
                    end
                end
            end
            WRITE: begin
                if (rise) begin
                    nxt_state = GAP;
                    nxt_rw    = 1'b1;
                end
            end
            GAP: begin
                if (rise) begin
                    if (last_col && last_row) begin
                        if (c_swap) begin
                            nxt_state = WAIT_NMI;
                            nxt_seen  = 1'b0;
                        end else begin
                            nxt_state = FINISH;
                            nxt_done  = 1'b1;
                            nxt_busy  = 1'b0;
                        end
                    end else begin
                        nxt_state = WRITE;
                        nxt_rw    = 1'b0;
                        nxt_dout  = c_fill;
                        if (last_col) begin
                            nxt_col      = '0;
                            nxt_row      = row + 8'd1;
                            nxt_row_base = row_base + {8'd0, c_stride};
                            nxt_addr     = row_base + {8'd0, c_stride};
                        end else begin
                            nxt_col  = col + 8'd1;
                            nxt_addr = row_base + {8'd0, col + 8'd1};
                        end
                    end
                end
            end
            WAIT_NMI: begin
                if (rise && (nmi_seen || nmi_fall)) begin
                    nxt_state = SWAP;
                    nxt_addr  = CFG_ADDR;
                    nxt_dout  = c_swap_data;
                    nxt_rw    = 1'b0;
                    nxt_seen  = 1'b0;
                end else if (nmi_fall) begin
                    nxt_seen = 1'b1;
                end
            end
            SWAP: begin
                if (rise) begin
                    nxt_state = SWAP_GAP;
                    nxt_rw    = 1'b1;
                end
            end
            SWAP_GAP: begin
                if (rise) begin
                    nxt_state = FINISH;
                    nxt_done  = 1'b1;
                    nxt_busy  = 1'b0;
                end
            end
            FINISH: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

endmodule
